uart_word_rx: RTL and testbench

//  Receive side of the 40-bit PC link. Deserialises 8N1 bytes from the rxd pin and packs WORD_BYTES bytes into one word.

---
 rtl/uart_word_rx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_word_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_rx
//  Purpose  : 8N1 (or 8E1 with UART_RX_PARITY_EN) serial receiver that packs
//             WORD_BYTES bytes, first byte in the MSBs, into one word
//             delivered over a valid/ack handshake.
//  Revision : 1.0
// ============================================================================
module uart_word_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int WORD_BYTES = 5,
    parameter int GAP_BITS   = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    input  logic                      recv_ack,
    output logic [8*WORD_BYTES-1:0]   recv_data,
    output logic                      recv_valid,
    output logic                      overrun,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int c_W         = 8 * WORD_BYTES;
    localparam int c_DIV       = CLK_FREQ / BAUD;
    localparam int c_CNT_W     = $clog2(c_DIV);
    localparam int c_GAP_LIMIT = GAP_BITS * c_DIV;
    localparam int c_GAP_W     = $clog2(c_GAP_LIMIT + 1);
    localparam int c_IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_DIV / 2 - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_LIMIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_rxd_meta;
    logic                   r_rxd_sync;
    logic                   r_armed;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_byte;
    logic [c_W-1:0]         r_word;
    logic [c_W-1:0]         w_word_next;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_GAP_W-1:0]     r_gap;
    logic [c_W-1:0]         r_recv_data;
    logic                   r_recv_valid;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_start_det;
    logic                   w_cnt_clr;
    logic                   w_bit_sample;
    logic                   w_stop_ok;
    logic                   w_stop_bad;
    logic                   w_par_err;
    logic                   w_word_done;
    logic                   w_gap_run;
    logic                   w_gap_expire;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_err;
    logic                   w_par_sample;
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // rxd is asynchronous to clk; only r_rxd_sync is used downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_bit_sample = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_armed && !r_rxd_sync) begin
                    w_start_det  = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rxd_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_bit_sample = 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_par_sample = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_IDLE;
                    if (r_rxd_sync && !w_par_err) begin
                        w_stop_ok  = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_word_next = r_word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (int'(r_idx) == k) begin
                w_word_next[c_W-1-8*k -: 8] = r_byte;
            end
        end
    end

    assign w_word_done  = w_stop_ok && (r_idx == c_IDX_LAST);
    assign w_gap_run    = (r_state == S_IDLE) && (r_idx != '0);
    assign w_gap_expire = w_gap_run && (r_gap == c_GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_byte       <= 8'd0;
            r_word       <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_armed      <= 1'b1;
            r_recv_data  <= '0;
            r_recv_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_stop_bad;

            if (w_cnt_clr || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_start_det) begin
                r_bit <= 3'd0;
            end else if (w_bit_sample) begin
                r_bit  <= r_bit + 3'd1;
                r_byte <= {r_rxd_sync, r_byte[7:1]};
            end

`ifdef UART_RX_PARITY_EN
            if (w_start_det) begin
                r_par_err <= 1'b0;
            end else if (w_par_sample) begin
                r_par_err <= r_rxd_sync ^ (^r_byte);
            end
`endif

            // After a low stop bit the line may still be in a break; wait for
            // it to return high so the tail is not taken as a new start bit
            if (w_stop_bad && !r_rxd_sync) begin
                r_armed <= 1'b0;
            end else if (!r_armed && r_rxd_sync) begin
                r_armed <= 1'b1;
            end

            if (w_stop_ok) begin
                r_word <= w_word_next;
            end

            if (w_stop_bad) begin
                r_idx <= '0;
            end else if (w_stop_ok) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else if (w_gap_expire) begin
                r_idx <= '0;
            end

            if (w_gap_run && !w_gap_expire) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            // A completion coinciding with an ack replaces the acked word
            // without counting as an overrun
            if (w_word_done) begin
                r_recv_data  <= w_word_next;
                r_recv_valid <= 1'b1;
                if (r_recv_valid) begin
                    r_overrun <= !recv_ack;
                end
            end else if (r_recv_valid && recv_ack) begin
                r_recv_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign recv_data  = r_recv_data;
    assign recv_valid = r_recv_valid;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE) || (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_word_rx
//  Purpose  : Self-checking bench for uart_word_rx at DIV=16, five-byte words.
//  Revision : 1.0
// ============================================================================
module tb_uart_word_rx;

    localparam int c_DIV = 16;
    localparam int c_W   = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             rxd;
    logic             recv_ack;
    logic [c_W-1:0]   recv_data;
    logic             recv_valid;
    logic             overrun;
    logic             frame_err;
    logic             busy;

    int nvec     = 0;
    int nerr     = 0;
    int cyc      = 0;
    int stop_mid = 0;
    int rise_cyc = 0;
    int fe_count = 0;
    int fe_long  = 0;
    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;

    uart_word_rx #(
        .CLK_FREQ   (1600000),
        .BAUD       (100000),
        .WORD_BYTES (5),
        .GAP_BITS   (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .recv_ack   (recv_ack),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= recv_valid;
        prev_fe    <= frame_err;
        if (frame_err === 1'b1) fe_count <= fe_count + 1;
        if (frame_err === 1'b1 && prev_fe === 1'b1) fe_long <= fe_long + 1;
        if (recv_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    // Line-level model of one character: start, 8 data LSB first, optional
    // even parity, stop; then idle_after extra high clocks
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_after);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (c_DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (c_DIV) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rxd = ^b;
        repeat (c_DIV) @(posedge clk);
`endif
        #1 rxd = stop_bit;
        stop_mid = cyc + c_DIV / 2;
        repeat (c_DIV) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (idle_after) @(posedge clk);
    endtask

    task automatic send_word(input logic [c_W-1:0] w, input int gap);
        for (int k = 0; k < 5; k++) begin
            send_byte(w[c_W-1-8*k -: 8], 1'b1, gap);
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 recv_ack = 1'b1;
        @(posedge clk);
        #1 recv_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxd = 1'b1;
        recv_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({recv_valid, overrun, frame_err, busy} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_flags: actual %b required 0000", {recv_valid, overrun, frame_err, busy});
        end
        nvec++;
        if (recv_data !== 40'h0) begin
            nerr++;
            $display("FAIL reset_data: actual %h required %h", recv_data, 40'h0);
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_all_ones();
        send_word(40'hFF_FFFF_FFFF, 0);
        for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        nvec++;
        if (recv_valid !== 1'b1 || recv_data !== 40'hFF_FFFF_FFFF) begin
            nerr++;
            $display("FAIL ones_word: actual valid=%b data=%h required valid=1 data=ffffffffff", recv_valid, recv_data);
        end
        nvec++;
        if (rise_cyc - stop_mid < 1 || rise_cyc - stop_mid > 4) begin
            nerr++;
            $display("FAIL ones_latency: actual %0d clks after stop mid, required 1..4", rise_cyc - stop_mid);
        end
        pulse_ack();
        nvec++;
        if (recv_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ones_ack: actual valid=%b required 0", recv_valid);
        end
    endtask

    task automatic test_ack();
        send_word(40'h12_3456_789A, 0);
        for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (recv_valid !== 1'b1 || recv_data !== 40'h12_3456_789A || overrun !== 1'b0) begin
            nerr++;
            $display("FAIL ack_word: actual valid=%b data=%h ovr=%b required valid=1 data=123456789a ovr=0",
                     recv_valid, recv_data, overrun);
        end
        pulse_ack();
        nvec++;
        if (recv_valid !== 1'b0 || overrun !== 1'b0) begin
            nerr++;
            $display("FAIL ack_drop: actual valid=%b ovr=%b required 0 0", recv_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        send_word(40'h11_2233_4455, 0);
        send_word(40'hAA_BBCC_DDEE, 0);
        for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
        nvec++;
        if (recv_valid !== 1'b1 || recv_data !== 40'hAA_BBCC_DDEE || overrun !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_word: actual valid=%b data=%h ovr=%b required valid=1 data=aabbccddee ovr=1",
                     recv_valid, recv_data, overrun);
        end
        pulse_ack();
        nvec++;
        if (recv_valid !== 1'b0 || overrun !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_clear: actual valid=%b ovr=%b required 0 0", recv_valid, overrun);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_count;
        send_byte(8'h3C, 1'b0, 32);
        nvec++;
        if (fe_count - fe0 != 1 || fe_long != 0) begin
            nerr++;
            $display("FAIL fe_pulse: actual pulses=%0d long=%0d required pulses=1 long=0", fe_count - fe0, fe_long);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL fe_discard: actual busy=%b required 0", busy);
        end
        send_word(40'hA1_B2C3_D4E5, 3);
        for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
        nvec++;
        if (recv_valid !== 1'b1 || recv_data !== 40'hA1_B2C3_D4E5) begin
            nerr++;
            $display("FAIL fe_word: actual valid=%b data=%h required valid=1 data=a1b2c3d4e5", recv_valid, recv_data);
        end
        pulse_ack();
    endtask

    task automatic test_gap();
        send_byte(8'hDE, 1'b1, 0);
        send_byte(8'hAD, 1'b1, 400);
        nvec++;
        if (recv_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL gap_drop: actual valid=%b busy=%b required 0 0", recv_valid, busy);
        end
        send_word(40'h01_0203_0405, 0);
        for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
        nvec++;
        if (recv_valid !== 1'b1 || recv_data !== 40'h01_0203_0405) begin
            nerr++;
            $display("FAIL gap_word: actual valid=%b data=%h required valid=1 data=0102030405", recv_valid, recv_data);
        end
        pulse_ack();
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_count;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL glitch_start: actual busy=%b required 1", busy);
        end
        repeat (40) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0 || recv_valid !== 1'b0 || fe_count != fe0) begin
            nerr++;
            $display("FAIL glitch_idle: actual busy=%b valid=%b fe=%0d required 0 0 0", busy, recv_valid, fe_count - fe0);
        end
    endtask

    task automatic test_random_words();
        logic [c_W-1:0] expw;
        logic [7:0]     b;
        for (int w = 0; w < 6; w++) begin
            expw = '0;
            for (int k = 0; k < 5; k++) begin
                b = 8'($urandom);
                expw = {expw[c_W-9:0], b};
                send_byte(b, 1'b1, (k == 4) ? 0 : int'($urandom_range(0, 250)));
            end
            for (int i = 0; i < 200 && recv_valid !== 1'b1; i++) @(negedge clk);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            nvec++;
            if (recv_valid !== 1'b1 || recv_data !== expw || overrun !== 1'b0) begin
                nerr++;
                $display("FAIL rand_word%0d: actual valid=%b data=%h ovr=%b required valid=1 data=%h ovr=0",
                         w, recv_valid, recv_data, overrun, expw);
            end
            pulse_ack();
            nvec++;
            if (recv_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rand_ack%0d: actual valid=%b required 0", w, recv_valid);
            end
        end
    endtask

    task automatic test_rst_mid();
        int fe0;
        send_word(40'h5A_A55A_A55A, 0);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b1 || recv_valid !== 1'b1) begin
            nerr++;
            $display("FAIL rst_pre: actual busy=%b valid=%b required 1 1", busy, recv_valid);
        end
        fe0 = fe_count;
        #2 rst = 1'b0;
        #1;
        nvec++;
        if ({recv_valid, overrun, frame_err, busy} !== 4'b0000 || recv_data !== 40'h0) begin
            nerr++;
            $display("FAIL rst_mid: actual flags=%b data=%h required 0000 0000000000",
                     {recv_valid, overrun, frame_err, busy}, recv_data);
        end
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        rst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        nvec++;
        if ({recv_valid, busy} !== 2'b00 || fe_count != fe0) begin
            nerr++;
            $display("FAIL rst_after: actual valid=%b busy=%b fe=%0d required 0 0 0", recv_valid, busy, fe_count - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ack();
        test_overrun();
        test_frame_err();
        test_gap();
        test_glitch();
        test_random_words();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
